// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_entry_t : one prefetch-queue entry {instr, pc} at the default widths.
//   PTR_W         : queue pointer width for the default depth.
package fetch_pkg;

    localparam int DEF_ADDR_W  = 24;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int PTR_W       = $clog2(DEF_DEPTH);

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding prefetched {instr, pc} entries.
//   clk, rst  : clock, async active-high reset
//   push      : write pushData at the tail
//   pop       : advance the head
//   flush     : empty the queue; overrides push and pop in the same cycle
//   pushData  : entry to write
//   headData  : entry at the head, all zeros while empty
//   count     : number of stored entries (0..DEPTH)
module fetch_queue #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] pushData,
    output logic [WIDTH-1:0] headData,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;

    // Storage needs no reset: an empty queue never exposes its contents.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            storage[wrPtr] <= pushData;
        end
    end

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign headData = (count != '0) ? storage[rdPtr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, combinational instruction-memory
// read, and a prefetch queue feeding decode through valid/ready.
//   clk, rst    : clock, async active-high reset
//   halt        : stop fetching; the queue keeps draining
//   branchFlag  : redirect to branchAddr, flushing the queue
//   branchAddr  : redirect target
//   imem_addr   : memory address, low bits of pc
//   imem_data   : memory read data for imem_addr
//   out_valid   : head entry valid
//   out_ready   : decode takes the head this cycle
//   out_instr   : head instruction (0 when empty)
//   out_pc      : head pc (0 when empty)
//   occupancy   : queued entry count
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int INSTR_W    = DEF_INSTR_W,
    parameter int MEM_ADDR_W = 14,
    parameter int PC_STEP    = 4,
    parameter int DEPTH      = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  branchFlag,
    input  logic [ADDR_W-1:0]     branchAddr,
    output logic [MEM_ADDR_W-1:0] imem_addr,
    input  logic [INSTR_W-1:0]    imem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INSTR_W-1:0]    out_instr,
    output logic [ADDR_W-1:0]     out_pc,
    output logic [OCC_W-1:0]      occupancy
);

    logic [ADDR_W-1:0]         pc;
    logic                      push;
    logic                      pop;
    logic [INSTR_W+ADDR_W-1:0] headData;

    assign out_valid = (occupancy != '0);
    assign pop       = out_valid && out_ready;
    // A full queue can still accept when its head leaves in the same cycle.
    assign push      = !halt && !branchFlag &&
                       ((occupancy < OCC_W'(DEPTH)) || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (branchFlag) begin
            pc <= branchAddr;
        end else if (push) begin
            pc <= pc + ADDR_W'(PC_STEP);
        end
    end

    assign imem_addr = pc[MEM_ADDR_W-1:0];

    fetch_queue #(
        .WIDTH(INSTR_W + ADDR_W),
        .DEPTH(DEPTH)
    ) uQueue (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (branchFlag),
        .pushData ({imem_data, pc}),
        .headData (headData),
        .count    (occupancy)
    );

    assign {out_instr, out_pc} = headData;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        halt;
    logic        branchFlag;
    logic [23:0] branchAddr;
    logic [13:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [23:0] out_pc;
    logic [2:0]  occupancy;

    logic [13:0] imem_addr2;
    logic [31:0] imem_data2;
    logic        out_valid2;
    logic [31:0] out_instr2;
    logic [23:0] out_pc2;
    logic [2:0]  occupancy2;

    int testCount = 0;
    int failCount = 0;
    fetch_entry_t expEntry;

    // Memory model: word i holds i + 0x100.
    assign imem_data  = 32'(imem_addr[13:2])  + 32'h100;
    assign imem_data2 = 32'(imem_addr2[13:2]) + 32'h100;

    fetch_unit dut (
        .clk(clk), .rst(rst), .halt(halt), .branchFlag(branchFlag),
        .branchAddr(branchAddr), .imem_addr(imem_addr), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .occupancy(occupancy)
    );

    fetch_unit #(.RESET_PC(24'hFFFFF8)) dutWrap (
        .clk(clk), .rst(rst), .halt(1'b0), .branchFlag(1'b0),
        .branchAddr(24'h0), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .out_valid(out_valid2), .out_ready(1'b1), .out_instr(out_instr2),
        .out_pc(out_pc2), .occupancy(occupancy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkHead(input string tag, input logic [23:0] pcExp, input logic [31:0] instrExp);
        expEntry.instr = instrExp;
        expEntry.pc    = pcExp;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_pc"}, 32'(out_pc), 32'(expEntry.pc));
        check({tag, "_instr"}, out_instr, expEntry.instr);
    endtask

    task automatic checkEmpty(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_occ"}, 32'(occupancy), 32'd0);
        check({tag, "_pc"}, 32'(out_pc), 32'd0);
        check({tag, "_instr"}, out_instr, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        halt = 1'b0;
        branchFlag = 1'b0;
        branchAddr = 24'h0;
        out_ready = 1'b1;
        #1 rst = 1'b1;

        // Reset state
        step();
        checkEmpty("reset");
        check("reset_imem_addr", 32'(imem_addr), 32'd0);
        check("reset_wrap_pc", 32'(out_pc2), 32'd0);
        rst = 1'b0;

        // Streaming after reset release; wrap instance runs alongside
        for (int i = 0; i < 4; i++) begin
            step();
            checkHead($sformatf("stream%0d", i), 24'(4 * i), 32'h100 + 32'(i));
            check($sformatf("stream%0d_occ", i), 32'(occupancy), 32'd1);
            if (i == 0) begin
                check("wrap0_pc", 32'(out_pc2), 32'hFFFFF8);
                check("wrap0_instr", out_instr2, 32'h10FE);
            end else if (i == 1) begin
                check("wrap1_pc", 32'(out_pc2), 32'hFFFFFC);
                check("wrap1_instr", out_instr2, 32'h10FF);
            end else if (i == 2) begin
                check("wrap2_pc", 32'(out_pc2), 32'h000000);
                check("wrap2_instr", out_instr2, 32'h100);
            end
        end

        // Async reset pulse between edges
        @(posedge clk);
        #2;
        check("pre_pulse_valid", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkEmpty("async_rst");
        check("async_rst_imem_addr", 32'(imem_addr), 32'd0);
        out_ready = 1'b0;
        #1 rst = 1'b0;

        // Fill with decode stalled: saturate at DEPTH, head stable
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("fill%0d_occ", k), 32'(occupancy), (k < 4) ? 32'(k) : 32'd4);
            checkHead($sformatf("fill%0d", k), 24'h0, 32'h100);
        end
        check("fill_imem_addr", 32'(imem_addr), 32'd16);

        // Drain while full: every cycle pops and pushes, no gaps
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            checkHead($sformatf("drain%0d", j), 24'(4 * (j + 1)), 32'h101 + 32'(j));
            check($sformatf("drain%0d_occ", j), 32'(occupancy), 32'd4);
        end

        // Redirect while full
        branchFlag = 1'b1;
        branchAddr = 24'h200;
        step();
        checkEmpty("branch");
        check("branch_imem_addr", 32'(imem_addr), 32'h200);
        branchFlag = 1'b0;
        step();
        checkHead("target0", 24'h200, 32'h180);
        step();
        checkHead("target1", 24'h204, 32'h181);

        // Build three entries, then halt and drain
        out_ready = 1'b0;
        step();
        step();
        check("prehalt_occ", 32'(occupancy), 32'd3);
        halt = 1'b1;
        out_ready = 1'b1;
        step();
        checkHead("halt_pop1", 24'h208, 32'h182);
        check("halt_pop1_occ", 32'(occupancy), 32'd2);
        step();
        checkHead("halt_pop2", 24'h20C, 32'h183);
        check("halt_pop2_occ", 32'(occupancy), 32'd1);
        step();
        checkEmpty("halt_empty");
        step();
        checkEmpty("halt_idle");
        check("halt_imem_addr", 32'(imem_addr), 32'h210);
        halt = 1'b0;
        step();
        checkHead("resume0", 24'h210, 32'h184);
        step();
        checkHead("resume1", 24'h214, 32'h185);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage with a prefetch queue. It generates the program counter, drives a combinational-read instruction memory, and buffers {instruction, pc} pairs in a DEPTH-entry queue. The queue feeds decode through a valid/ready handshake. Branch redirects flush the queue, and a halt input freezes fetch. The block sits between the instruction memory and the decode stage, replacing the fixed single-register fetch buffer.

## Interface
- ADDR_W, 24: PC width.
- INSTR_W, 32: instruction width.
- MEM_ADDR_W, 14: instruction-memory address width; the memory is driven with pc[MEM_ADDR_W-1:0].
- PC_STEP, 4: PC increment per fetch (byte-addressed memory).
- DEPTH, 4: prefetch queue entries; power of two, at least 2.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- halt  in  1  suppresses new fetches; the queue still drains.
- branchFlag  in  1  redirect request.
- branchAddr  in  ADDR_W  redirect target.
- imem_addr  out  MEM_ADDR_W  memory address, equal to pc[MEM_ADDR_W-1:0].
- imem_data  in  INSTR_W  memory data, combinational from imem_addr.
- out_valid  out  1  queue head holds a valid entry.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  INSTR_W  head instruction; 0 when empty.
- out_pc  out  ADDR_W  head PC; 0 when empty.
- occupancy  out  $clog2(DEPTH)+1  current entry count.

## Operation
- Reset state: pc=RESET_PC, queue empty, occupancy=0, out_valid=0, out_instr=0, out_pc=0.
- pop = out_valid & out_ready.
- push = !halt & !branchFlag & (occupancy<DEPTH | pop). Push writes {imem_data, pc} at the tail, and pc <= pc+PC_STEP.
- PC arithmetic is modulo 2^ADDR_W: 2^ADDR_W-PC_STEP wraps to 0.
- Redirect has priority over everything. When branchFlag=1:
  - occupancy <= 0 and pointers are reset;
  - pc <= branchAddr;
  - any push or pop in that cycle is discarded; decode must ignore the handshake in that cycle.
- Halt: pc holds and no push occurs. Pops continue. Redirect is still honoured while halted.
- Full and pop in the same cycle: push and pop both occur, so occupancy is unchanged.
- Empty and push in the same cycle: the entry becomes visible the next cycle. There is no bypass.
- Pointers wrap modulo DEPTH. Occupancy distinguishes full from empty.
- Output stability: while out_valid=1 and out_ready=0, out_instr and out_pc hold unchanged. A redirect is the only exception.
- Asserting rst mid-operation returns every register to its reset state immediately, without waiting for a clock edge.

## Timing
- Fetch-to-visible latency: 1 cycle. An entry pushed at edge N is at the head, if the queue was empty, with out_valid=1 after edge N.
- First valid output: the first rising edge after rst deasserts performs the push; out_valid goes high after that edge and presents {mem[RESET_PC], RESET_PC}.
- Redirect asserted across edge N gives out_valid=0 after N. Edge N+1 pushes the target, so the target appears after N+1. The redirect bubble is 1 cycle.
- Sustained throughput with out_ready=1 and no halt: 1 instruction per cycle.
- imem_addr changes only after a clock edge. It tracks pc combinationally.

## Structure
- fetch_pkg holds:
  - fetch_entry_t, a packed struct {instr [INSTR_W-1:0], pc [ADDR_W-1:0]}, using package-level default widths;
  - the localparam PTR_W = $clog2(DEPTH).
- One sub-module, fetch_queue: a parametrised synchronous FIFO with async reset, push/pop/flush, occupancy, and a zeroed head when empty.
- fetch_unit contains the PC register, the push/pop/redirect control, and the fetch_queue instance.

## Test plan
- Reset release with out_ready=1 and mem[i]=i+0x100 (word index): out_pc sequence 0,4,8,12 on consecutive cycles, with instr 0x100,0x101,0x102,0x103.
- out_ready=0 for 10 cycles: occupancy saturates at 4 and pc stops at 16. Head stays {0x100,0}. Then out_ready=1 yields PCs 0,4,8,... with no gaps or duplicates.
- Queue full with a branch to 0x200: after the edge, occupancy=0 and out_valid=0. On the next cycle the head is {mem[0x200],0x200}; then 0x204 follows.
- halt=1 with 3 entries queued and out_ready=1: three pops, then out_valid=0, with pc unchanged. Releasing halt resumes from the held pc.
- RESET_PC=24'hFFFFF8 with continuous pops: out_pc sequence FFFFF8, FFFFFC, 000000.
- rst pulsed asynchronously mid-stream, between clock edges: outputs go to zero and occupancy to 0 immediately. Fetch restarts at RESET_PC.
